// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU/branch encodings and the ID/EX control bundle.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_LT = 2'b10;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic [2:0] alu_control;
    logic [1:0] branch_op;
    logic       slt_c;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  // A bubble must have no architectural side effect and a benign ALU op.
  localparam ctrl_t BUBBLE_CTRL = '{
    alu_control: ALU_ADD,
    branch_op:   BR_EQ,
    slt_c:       1'b0,
    alu_src:     1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    reg_write:   1'b0,
    mem_to_reg:  1'b0,
    branch:      1'b0
  };

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detector: a load in EX whose rd feeds a source of the ID instruction.
module hazard_unit (
  input  logic       valid_ex,
  input  logic       mem_read_ex,
  input  logic [4:0] rd_ex,
  input  logic       valid_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  output logic       haz
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign haz = valid_ex & mem_read_ex & (rd_ex != 5'd0) & valid_id &
               ((rd_ex == rs1_id) | (rd_ex == rs2_id));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion and a bubble counter.
module id_ex_reg #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_id,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [XLEN-1:0]  rs1_data_id,
  input  logic [XLEN-1:0]  rs2_data_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic [2:0]       ALUControl_id,
  input  logic [1:0]       BranchOp_id,
  input  logic             SLTc_id,
  input  logic             ALUSrc_id,
  input  logic             MemRead_id,
  input  logic             MemWrite_id,
  input  logic             RegWrite_id,
  input  logic             MemToReg_id,
  input  logic             Branch_id,
  input  logic             flush_ex,
  input  logic             hold,
  output logic             valid_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  rs1_data_ex,
  output logic [XLEN-1:0]  rs2_data_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic [2:0]       ALUControl_ex,
  output logic [1:0]       BranchOp_ex,
  output logic             SLTc_ex,
  output logic             ALUSrc_ex,
  output logic             MemRead_ex,
  output logic             MemWrite_ex,
  output logic             RegWrite_ex,
  output logic             MemToReg_ex,
  output logic             Branch_ex,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt
);
  import riscv_pkg::*;

  ctrl_t ctrl_d, ctrl_q;
  logic  haz;

  assign ctrl_d = '{
    alu_control: ALUControl_id,
    branch_op:   BranchOp_id,
    slt_c:       SLTc_id,
    alu_src:     ALUSrc_id,
    mem_read:    MemRead_id,
    mem_write:   MemWrite_id,
    reg_write:   RegWrite_id,
    mem_to_reg:  MemToReg_id,
    branch:      Branch_id
  };

  hazard_unit u_haz (
    .valid_ex    (valid_ex),
    .mem_read_ex (ctrl_q.mem_read),
    .rd_ex       (rd_ex),
    .valid_id    (valid_id),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .haz         (haz)
  );

  // A flush already kills the dependent instruction, so no stall is needed.
  assign stall_o = haz & ~flush_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_ex    <= 1'b0;
      ctrl_q      <= '0;
      pc_ex       <= '0;
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= '0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      rd_ex       <= '0;
      bubble_cnt  <= '0;
    end else if (flush_ex || (!hold && haz)) begin
      // Data fields are left as-is: they are dead once valid_ex drops.
      valid_ex <= 1'b0;
      ctrl_q   <= BUBBLE_CTRL;
      if (!(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (!hold) begin
      valid_ex    <= valid_id;
      ctrl_q      <= ctrl_d;
      pc_ex       <= pc_id;
      rs1_data_ex <= rs1_data_id;
      rs2_data_ex <= rs2_data_id;
      imm_ex      <= imm_id;
      rs1_ex      <= rs1_id;
      rs2_ex      <= rs2_id;
      rd_ex       <= rd_id;
    end
  end

  assign ALUControl_ex = ctrl_q.alu_control;
  assign BranchOp_ex   = ctrl_q.branch_op;
  assign SLTc_ex       = ctrl_q.slt_c;
  assign ALUSrc_ex     = ctrl_q.alu_src;
  assign MemRead_ex    = ctrl_q.mem_read;
  assign MemWrite_ex   = ctrl_q.mem_write;
  assign RegWrite_ex   = ctrl_q.reg_write;
  assign MemToReg_ex   = ctrl_q.mem_to_reg;
  assign Branch_ex     = ctrl_q.branch;

endmodule
